// File: rtl/afifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO. The Gray/binary converters
// work on MAX_W-bit vectors; callers zero-extend in and size-cast back out.
package afifo_pkg;

  localparam int MAX_W     = 32;
  localparam int DEF_WIDTH = 4;
  localparam int ADDR_W    = DEF_WIDTH - 1;
  localparam int DEPTH     = 2 ** (DEF_WIDTH - 1);

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits stay zero, so the result is exact for any narrower pointer.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Multi-flop synchronizer bringing the read-domain Gray pointer into wclk.
// Only the last stage is exported; no combinational path from d to q.
module sync_r2w #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [SYNC_STAGES];

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
          stage_reg[0] <= '0;
        end else begin
          stage_reg[0] <= d;
        end
      end
    end else begin : g_rest
      always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
          stage_reg[gi] <= '0;
        end else begin
          stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full flag, occupancy and overflow for the async FIFO.
// Define AFIFO_ALMOST_FULL_EN to add the registered wafull output.
module wptr_full_ctrl
  import afifo_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic [WIDTH-1:0] rptr,
  output logic [WIDTH-2:0] waddr,
  output logic [WIDTH-1:0] wptr,
  output logic             wfull,
  output logic [WIDTH-1:0] wcount,
`ifdef AFIFO_ALMOST_FULL_EN
  output logic             wafull,
`endif
  output logic             wovf
);

  logic [WIDTH-1:0] wbin_reg;
  logic [WIDTH-1:0] wptr_reg;
  logic             wfull_reg;
  logic             wovf_reg;

  logic [WIDTH-1:0] rq2_rptr;
  logic [WIDTH-1:0] rq2_bin;
  logic [WIDTH-1:0] wbin_next;
  logic [WIDTH-1:0] wgray_next;
  logic [WIDTH-1:0] full_gray;
  logic             winc_ok;
  logic             wfull_next;

  sync_r2w #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_r2w (
    .wclk (wclk),
    .wrst (wrst),
    .d    (rptr),
    .q    (rq2_rptr)
  );

  assign winc_ok    = winc & ~wfull_reg;
  assign wbin_next  = wbin_reg + {{(WIDTH-1){1'b0}}, winc_ok};
  assign wgray_next = WIDTH'(bin2gray(MAX_W'(wbin_next)));
  assign rq2_bin    = WIDTH'(gray2bin(MAX_W'(rq2_rptr)));

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray code that means the top two bits differ, the rest match.
  assign full_gray  = {~rq2_rptr[WIDTH-1:WIDTH-2], rq2_rptr[WIDTH-3:0]};
  assign wfull_next = (wgray_next == full_gray);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_reg  <= '0;
      wptr_reg  <= '0;
      wfull_reg <= 1'b0;
      wovf_reg  <= 1'b0;
    end else begin
      wbin_reg  <= wbin_next;
      wptr_reg  <= wgray_next;
      wfull_reg <= wfull_next;
      wovf_reg  <= winc & wfull_reg;
    end
  end

  assign waddr  = wbin_reg[WIDTH-2:0];
  assign wptr   = wptr_reg;
  assign wfull  = wfull_reg;
  assign wovf   = wovf_reg;
  // Stale read pointer makes this an over-estimate, which is the safe side.
  assign wcount = wbin_reg - rq2_bin;

`ifdef AFIFO_ALMOST_FULL_EN
  localparam logic [WIDTH-1:0] AFULL_LVL = WIDTH'(AFULL_THRESH);

  logic [WIDTH-1:0] level_next;
  logic             wafull_reg;

  assign level_next = wbin_next - rq2_bin;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wafull_reg <= 1'b0;
    end else begin
      wafull_reg <= (level_next >= AFULL_LVL);
    end
  end

  assign wafull = wafull_reg;
`endif

endmodule
